mem_arbiter: RTL and testbench

Two-to-one arbiter that shares one SRAM-like memory port between the core's instruction-fetch requester and its data-access requester. It sits between the core's instruction and data request channels and the single external memory port, so the core runs on a unified memory. At most one transaction is in flight. Data requests have priority, with a starvation guard for fetch.

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-to-one arbiter sharing one SRAM-like memory port between instruction fetch
// and data access; data has priority, with a burst limit that guarantees fetch progress.
module mem_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DATA_BURST_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] BURST_LIMIT = 2'(DATA_BURST_MAX);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t     state;
  state_t     next_state;
  logic       grant_inst;
  logic       grant_data;
  logic       complete;
  logic       owner_data;
  logic [1:0] burst_cnt;

  // Grant decision and transaction sequencing
  always_comb begin
    next_state = state;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        grant_data = data_req && !(inst_req && (burst_cnt == BURST_LIMIT));
        grant_inst = inst_req && !grant_data;
        if (grant_data || grant_inst) next_state = ADDR;
      end
      ADDR: begin
        if (mem_addr_ok) begin
          if (mem_data_ok) begin
            complete   = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = DATA;
          end
        end
      end
      DATA: begin
        if (mem_data_ok) begin
          complete   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Request latch, response capture and status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_data   <= 1'b0;
      mem_req      <= 1'b0;
      mem_wr       <= 1'b0;
      mem_wstrb    <= 4'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      inst_rdata   <= '0;
      data_rdata   <= '0;
    end else begin
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      if (grant_data) begin
        owner_data <= 1'b1;
        mem_req    <= 1'b1;
        busy       <= 1'b1;
        mem_wr     <= data_wr;
        mem_wstrb  <= data_wr ? data_wstrb : 4'b0;
        mem_addr   <= data_addr;
        mem_wdata  <= data_wdata;
      end else if (grant_inst) begin
        owner_data <= 1'b0;
        mem_req    <= 1'b1;
        busy       <= 1'b1;
        mem_wr     <= 1'b0;
        mem_wstrb  <= 4'b0;
        mem_addr   <= inst_addr;
        mem_wdata  <= '0;
      end
      if (state == ADDR && mem_addr_ok) mem_req <= 1'b0;
      if (complete) begin
        busy <= 1'b0;
        if (owner_data) begin
          data_data_ok <= 1'b1;
          data_rdata   <= mem_wr ? '0 : mem_rdata;
        end else begin
          inst_data_ok <= 1'b1;
          inst_rdata   <= mem_rdata;
        end
      end
    end
  end

  // Consecutive data grants while fetch waits; saturates at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= 2'd0;
    end else if (grant_data) begin
      if (!inst_req)                      burst_cnt <= 2'd0;
      else if (burst_cnt != BURST_LIMIT)  burst_cnt <= burst_cnt + 2'd1;
    end else if (grant_inst) begin
      burst_cnt <= 2'd0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table-driven single transactions plus
// hand-written burst, reset-abort and stray-response sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok = 1'b0;
  logic        mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_BURST_MAX(2)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwr;
    logic [3:0]  dstrb;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    int          stall;
    logic        comb;
    logic [31:0] rdata;
    logic        exp_inst;
    logic        exp_wr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_addr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs[7];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_irdata = '0;
  logic [31:0] m_drdata = '0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_req_fields(input vec_t v, input logic req_exp);
    chk1("mem_req", mem_req, req_exp);
    chk1("busy_addr", busy, 1'b1);
    chk1("mem_wr", mem_wr, v.exp_wr);
    chk32("mem_wstrb", 32'(mem_wstrb), 32'(v.exp_wstrb));
    chk32("mem_addr", mem_addr, v.exp_addr);
    if (!v.exp_inst) chk32("mem_wdata", mem_wdata, v.dwdata);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk1({tag, "_inst_data_ok"}, inst_data_ok, 1'b0);
    chk1({tag, "_data_data_ok"}, data_data_ok, 1'b0);
    chk32({tag, "_inst_rdata"}, inst_rdata, m_irdata);
    chk32({tag, "_data_rdata"}, data_rdata, m_drdata);
  endtask

  // One complete transaction, starting just after a rising edge with the arbiter idle
  task automatic run_txn(input vec_t v);
    inst_req = v.ireq;  inst_addr = v.iaddr;
    data_req = v.dreq;  data_wr = v.dwr;  data_wstrb = v.dstrb;
    data_addr = v.daddr; data_wdata = v.dwdata;
    @(negedge clk);
    chk1("inst_addr_ok", inst_addr_ok, v.exp_inst);
    chk1("data_addr_ok", data_addr_ok, !v.exp_inst);
    chk1("busy_idle", busy, 1'b0);
    tick();
    inst_req = 1'b0;
    data_req = 1'b0;
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      chk_req_fields(v, 1'b1);
      tick();
    end
    mem_addr_ok = 1'b1;
    mem_data_ok = v.comb;
    mem_rdata   = v.rdata;
    @(negedge clk);
    chk_req_fields(v, 1'b1);
    tick();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    if (!v.comb) begin
      mem_data_ok = 1'b1;
      @(negedge clk);
      chk1("mem_req_data", mem_req, 1'b0);
      chk1("busy_data", busy, 1'b1);
      chk1("early_data_ok", inst_data_ok | data_data_ok, 1'b0);
      tick();
      mem_data_ok = 1'b0;
    end
    if (v.exp_inst) m_irdata = v.exp_rd;
    else            m_drdata = v.exp_rd;
    @(negedge clk);
    chk1("inst_data_ok", inst_data_ok, v.exp_inst);
    chk1("data_data_ok", data_data_ok, !v.exp_inst);
    chk32("inst_rdata", inst_rdata, m_irdata);
    chk32("data_rdata", data_rdata, m_drdata);
    chk1("busy_done", busy, 1'b0);
    tick();
    @(negedge clk);
    chk1("pulse_end_inst", inst_data_ok, 1'b0);
    chk1("pulse_end_data", data_data_ok, 1'b0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_seq[6];
    exp_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    //        ireq  iaddr         dreq  dwr   dstrb    daddr         dwdata        st comb rdata        inst  wr    wstrb    addr          rd
    vecs[0] = '{1'b1, 32'hBFC00000, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        0, 1'b0, 32'h3C1D0001, 1'b1, 1'b0, 4'b0000, 32'hBFC00000, 32'h3C1D0001};
    vecs[1] = '{1'b0, 32'h0,        1'b1, 1'b1, 4'b0011, 32'h80001000, 32'h1234ABCD, 3, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 4'b0011, 32'h80001000, 32'h00000000};
    vecs[2] = '{1'b0, 32'h0,        1'b1, 1'b0, 4'b1111, 32'h80002000, 32'h55555555, 0, 1'b0, 32'h11223344, 1'b0, 1'b0, 4'b0000, 32'h80002000, 32'h11223344};
    vecs[3] = '{1'b0, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h00000010, 32'h0,        0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 4'b0000, 32'h00000010, 32'hFFFFFFFF};
    vecs[4] = '{1'b1, 32'hBFC00004, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        1, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 4'b0000, 32'hBFC00004, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 32'hBFC00008, 1'b1, 1'b1, 4'b1100, 32'h80003000, 32'hA5A5A5A5, 0, 1'b0, 32'h0BADF00D, 1'b0, 1'b1, 4'b1100, 32'h80003000, 32'h00000000};
    vecs[6] = '{1'b1, 32'hBFC0000C, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        2, 1'b0, 32'h24080001, 1'b1, 1'b0, 4'b0000, 32'hBFC0000C, 32'h24080001};

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    chk_idle_outputs("rst");
    rst = 1'b0;
    tick();

    foreach (vecs[i]) run_txn(vecs[i]);

    // Both requesters held high: data, data, inst repeating
    inst_req = 1'b1; inst_addr = 32'hBFC00100;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80004000;
    for (int g = 0; g < 6; g++) begin
      @(negedge clk);
      if (g > 0) begin
        chk1("burst_inst_data_ok", inst_data_ok, exp_seq[g-1]);
        chk1("burst_data_data_ok", data_data_ok, !exp_seq[g-1]);
        chk32("burst_inst_rdata", inst_rdata, m_irdata);
        chk32("burst_data_rdata", data_rdata, m_drdata);
      end
      chk1("burst_inst_grant", inst_addr_ok, exp_seq[g]);
      chk1("burst_data_grant", data_addr_ok, !exp_seq[g]);
      tick();
      mem_addr_ok = 1'b1;
      mem_rdata = 32'h100 + 32'(g);
      tick();
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b1;
      if (g == 5) begin
        inst_req = 1'b0;
        data_req = 1'b0;
      end
      if (exp_seq[g]) m_irdata = 32'h100 + 32'(g);
      else            m_drdata = 32'h100 + 32'(g);
      tick();
      mem_data_ok = 1'b0;
    end
    @(negedge clk);
    chk1("burst_last_inst_data_ok", inst_data_ok, 1'b1);
    chk32("burst_last_inst_rdata", inst_rdata, m_irdata);
    chk1("burst_no_regrant", inst_addr_ok | data_addr_ok, 1'b0);
    tick();

    // Reset while waiting in DATA abandons the transaction
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80005000;
    tick();
    data_req = 1'b0;
    mem_addr_ok = 1'b1;
    tick();
    mem_addr_ok = 1'b0;
    @(negedge clk);
    chk1("pre_rst_busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    m_irdata = '0;
    m_drdata = '0;
    chk1("async_rst_busy", busy, 1'b0);
    chk1("async_rst_mem_req", mem_req, 1'b0);
    chk32("async_rst_mem_addr", mem_addr, 32'h0);
    chk32("async_rst_mem_wdata", mem_wdata, 32'h0);
    chk_idle_outputs("async_rst");
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_idle_outputs("post_rst");
      chk1("post_rst_busy", busy, 1'b0);
      tick();
    end
    run_txn(vecs[2]);

    // Stray handshakes while idle are ignored
    mem_addr_ok = 1'b1;
    mem_data_ok = 1'b1;
    mem_rdata = 32'h5A5A5A5A;
    tick();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk_idle_outputs("stray");
    chk1("stray_busy", busy, 1'b0);
    chk1("stray_mem_req", mem_req, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
